wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_pkg.sv | 18 +
 rtl/wb_grant.sv | 52 +++++
 rtl/wb_port_arbiter.sv | 116 +++++++++++
 tb/tb_wb_port_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Types and constants shared by the write-port arbiter and its grant logic.
package wb_port_arbiter_pkg;

  localparam int BURST_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] cnt,
                                                 input logic [BURST_W-1:0] lim);
    return (cnt >= lim) ? lim : cnt + BURST_W'(1);
  endfunction

endpackage

// File: rtl/wb_grant.sv
// Combinational grant decision between two write requesters.
// A locked owner keeps the port under contention until its burst limit is reached.
module wb_grant
  import wb_port_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  state_t             i_state,
  input  logic [BURST_W-1:0] i_burst_cnt,
  input  logic               i_last_grant,
  input  logic               i_valid0,
  input  logic               i_valid1,
  input  logic               i_lock0,
  input  logic               i_lock1,
  output logic               o_gnt0,
  output logic               o_gnt1
);

  localparam logic [BURST_W-1:0] LP_CNT_MAX = BURST_W'(MAX_BURST - 1);

  logic w_may_extend;

  assign w_may_extend = (i_burst_cnt < LP_CNT_MAX);

  // pick at most one requester; a lone requester always wins
  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    case ({i_valid0, i_valid1})
      2'b10: o_gnt0 = 1'b1;
      2'b01: o_gnt1 = 1'b1;
      2'b11: begin
        case (i_state)
          ST_OWN0: begin
            if (i_lock0 && w_may_extend) o_gnt0 = 1'b1;
            else                         o_gnt1 = 1'b1;
          end
          ST_OWN1: begin
            if (i_lock1 && w_may_extend) o_gnt1 = 1'b1;
            else                         o_gnt0 = 1'b1;
          end
          default: begin
            if (i_last_grant) o_gnt0 = 1'b1;
            else              o_gnt1 = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Two-requester arbiter in front of a shared register-file write port.
//
//   state   | meaning
//   --------+------------------------------------------
//   ST_IDLE | no transfer happened last cycle
//   ST_OWN0 | requester 0 transferred last cycle
//   ST_OWN1 | requester 1 transferred last cycle
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [WIDTH-1:0]  req0_data,
  input  logic              req0_lock,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [WIDTH-1:0]  req1_data,
  input  logic              req1_lock,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              wr_src
);

  localparam logic [BURST_W-1:0] LP_CNT_MAX = BURST_W'(MAX_BURST - 1);

  state_t             r_state, w_state_nxt;
  logic               r_last_grant, w_last_grant_nxt;
  logic [BURST_W-1:0] r_burst_cnt, w_burst_cnt_nxt;
  logic               w_gnt0, w_gnt1;

  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [WIDTH-1:0]   r_wr_data;
  logic               r_wr_src;

  wb_grant #(.MAX_BURST(MAX_BURST)) u_grant (
    .i_state      (r_state),
    .i_burst_cnt  (r_burst_cnt),
    .i_last_grant (r_last_grant),
    .i_valid0     (req0_valid),
    .i_valid1     (req1_valid),
    .i_lock0      (req0_lock),
    .i_lock1      (req1_lock),
    .o_gnt0       (w_gnt0),
    .o_gnt1       (w_gnt1)
  );

  // ready is forced low while reset is held, independent of the clock
  assign req0_ready = w_gnt0 & rst_n;
  assign req1_ready = w_gnt1 & rst_n;

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign wr_src  = r_wr_src;

  // arbitration state register; last_grant resets to 1 so requester 0 wins first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
    end
  end

  // next owner, last grant and burst length from this cycle's transfer
  always_comb begin
    w_state_nxt      = ST_IDLE;
    w_last_grant_nxt = r_last_grant;
    w_burst_cnt_nxt  = '0;
    if (w_gnt0) begin
      w_state_nxt      = ST_OWN0;
      w_last_grant_nxt = 1'b0;
      if (r_state == ST_OWN0) w_burst_cnt_nxt = sat_inc(r_burst_cnt, LP_CNT_MAX);
    end else if (w_gnt1) begin
      w_state_nxt      = ST_OWN1;
      w_last_grant_nxt = 1'b1;
      if (r_state == ST_OWN1) w_burst_cnt_nxt = sat_inc(r_burst_cnt, LP_CNT_MAX);
    end
  end

  // register the granted write one cycle after the handshake; fields hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_src  <= 1'b0;
    end else begin
      r_wr_en <= w_gnt0 | w_gnt1;
      if (w_gnt0) begin
        r_wr_addr <= req0_addr;
        r_wr_data <= req0_data;
        r_wr_src  <= 1'b0;
      end else if (w_gnt1) begin
        r_wr_addr <= req1_addr;
        r_wr_data <= req1_data;
        r_wr_src  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: each beat drives requests, checks the
// combinational grant, then checks the registered write one cycle later.
module tb_wb_port_arbiter;

  localparam int WIDTH     = 32;
  localparam int ADDR_W    = 5;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0_valid, req0_ready, req0_lock;
  logic              req1_valid, req1_ready, req1_lock;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [WIDTH-1:0]  req0_data, req1_data;
  logic              wr_en, wr_src;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  logic [ADDR_W-1:0] exp_addr = '0;
  logic [WIDTH-1:0]  exp_data = '0;
  logic              exp_src  = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  wb_port_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_lock  (req0_lock),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_lock  (req1_lock),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_src     (wr_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // g: expected grant (0, 1) or -1 for none
  task automatic beat(input string tag, input logic v0, input logic v1,
                      input logic l0, input logic l1, input int g);
    req0_valid = v0;
    req1_valid = v1;
    req0_lock  = l0;
    req1_lock  = l1;
    #1;
    check({tag, ".rdy0"}, 64'(req0_ready), 64'(g == 0));
    check({tag, ".rdy1"}, 64'(req1_ready), 64'(g == 1));
    @(posedge clk);
    #1;
    if (g == 0) begin
      exp_addr = req0_addr; exp_data = req0_data; exp_src = 1'b0;
    end else if (g == 1) begin
      exp_addr = req1_addr; exp_data = req1_data; exp_src = 1'b1;
    end
    check({tag, ".en"},   64'(wr_en),   64'(g >= 0));
    check({tag, ".addr"}, 64'(wr_addr), 64'(exp_addr));
    check({tag, ".data"}, 64'(wr_data), 64'(exp_data));
    check({tag, ".src"},  64'(wr_src),  64'(exp_src));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".en"},   64'(wr_en),      64'd0);
    check({tag, ".addr"}, 64'(wr_addr),    64'd0);
    check({tag, ".data"}, 64'(wr_data),    64'd0);
    check({tag, ".src"},  64'(wr_src),     64'd0);
    check({tag, ".rdy0"}, 64'(req0_ready), 64'd0);
    check({tag, ".rdy1"}, 64'(req1_ready), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req0_addr  = 5'd3;
    req0_data  = 32'hDEAD_BEEF;
    req1_addr  = 5'd17;
    req1_data  = 32'h1234_5678;
    req0_lock  = 1'b0;
    req1_lock  = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    check_reset_outputs("rst");

    @(negedge clk);
    rst_n = 1'b1;

    beat("single0", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    beat("idle_a",  1'b0, 1'b0, 1'b0, 1'b0, -1);
    beat("single1", 1'b0, 1'b1, 1'b0, 1'b0, 1);
    beat("idle_b",  1'b0, 1'b0, 1'b0, 1'b0, -1);

    for (int i = 0; i < 6; i++) beat("altern", 1'b1, 1'b1, 1'b0, 1'b0, i % 2);

    for (int i = 0; i < MAX_BURST - 1; i++) beat("lock1", 1'b1, 1'b1, 1'b0, 1'b1, 1);
    beat("lock1_sw",  1'b1, 1'b1, 1'b0, 1'b1, 0);
    beat("lock_nonown", 1'b1, 1'b1, 1'b0, 1'b1, 1);
    beat("idle_c",    1'b0, 1'b0, 1'b0, 1'b0, -1);

    beat("lock0_a", 1'b1, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++) beat("lock0_solo", 1'b1, 1'b0, 1'b1, 1'b1, 0);
    beat("lock0_sat", 1'b1, 1'b1, 1'b1, 1'b0, 1);

    beat("mid_burst", 1'b1, 1'b1, 1'b0, 1'b1, 1);
    rst_n = 1'b0;
    #1;
    exp_addr = '0;
    exp_data = '0;
    exp_src  = 1'b0;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    beat("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 0);

    req1_data = 32'h8000_0000;
    beat("neg_data", 1'b0, 1'b1, 1'b0, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
